// File: rtl/video_timing_pkg.sv
// Shared raster constants, colour constants and coordinate type for the video pipeline.
// Timing sets are plain ints; the driver narrows them to the 11-bit coordinate width.
package video_timing_pkg;

    localparam int COORD_W = 11;
    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [23:0]        rgb_t;

    // 1280x720@60, 74.25 MHz
    localparam int H720_SYNC = 40,  H720_BACK = 220, H720_DISP = 1280, H720_TOTAL = 1650;
    localparam int V720_SYNC = 5,   V720_BACK = 20,  V720_DISP = 720,  V720_TOTAL = 750;

    // 640x480@60, 25.175 MHz
    localparam int H480_SYNC = 96,  H480_BACK = 48,  H480_DISP = 640,  H480_TOTAL = 800;
    localparam int V480_SYNC = 2,   V480_BACK = 33,  V480_DISP = 480,  V480_TOTAL = 525;

    // 1920x1080@60, 148.5 MHz; H total exceeds the 11-bit counter, so it needs a wider build
    localparam int H1080_SYNC = 44, H1080_BACK = 148, H1080_DISP = 1920, H1080_TOTAL = 2200;
    localparam int V1080_SYNC = 5,  V1080_BACK = 36,  V1080_DISP = 1080, V1080_TOTAL = 1125;

    localparam rgb_t BLACK = 24'h000000;
    localparam rgb_t WHITE = 24'hFFFFFF;
    localparam rgb_t BLUE  = 24'h0000FF;
    localparam rgb_t GREEN = 24'h00FF00;

endpackage

// File: rtl/video_axis_counter.sv
// One raster axis: free-running position counter with raw sync/active decode and a wrap strobe.
// The vertical instance is clocked every pixel but only advances when enable (horizontal wrap) is set.
module video_axis_counter
    import video_timing_pkg::*;
#(
    parameter coord_t SYNC  = coord_t'(H720_SYNC),
    parameter coord_t BACK  = coord_t'(H720_BACK),
    parameter coord_t DISP  = coord_t'(H720_DISP),
    parameter coord_t TOTAL = coord_t'(H720_TOTAL)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    output logic [COORD_W-1:0] count,
    output logic               sync,
    output logic               active,
    output logic               wrap
);

    localparam coord_t ACT_START = coord_t'(SYNC + BACK);
    localparam coord_t ACT_END   = coord_t'(SYNC + BACK + DISP);
    localparam coord_t LAST      = coord_t'(TOTAL - 1);
    localparam coord_t ONE       = coord_t'(1);

    assign wrap   = enable && (count == LAST);
    assign sync   = (count < SYNC);
    assign active = (count >= ACT_START) && (count < ACT_END);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst)         count <= '0;
        else if (wrap)   count <= '0;
        else if (enable) count <= count + ONE;
    end

endmodule

// File: rtl/video_timing_driver.sv
// Raster timing generator: issues pixel coordinates one clock ahead of active video and
// re-emits the generator's registered pixel_data aligned with sync/DE for the TMDS encoder.
module video_timing_driver
    import video_timing_pkg::*;
#(
    parameter coord_t H_SYNC   = coord_t'(H720_SYNC),
    parameter coord_t H_BACK   = coord_t'(H720_BACK),
    parameter coord_t H_DISP   = coord_t'(H720_DISP),
    parameter coord_t H_TOTAL  = coord_t'(H720_TOTAL),
    parameter coord_t V_SYNC   = coord_t'(V720_SYNC),
    parameter coord_t V_BACK   = coord_t'(V720_BACK),
    parameter coord_t V_DISP   = coord_t'(V720_DISP),
    parameter coord_t V_TOTAL  = coord_t'(V720_TOTAL),
    parameter logic   SYNC_POL = 1'b1
) (
    input  logic               pixel_clk,
    input  logic               sys_rst,
    input  logic [23:0]        pixel_data,
    output logic               video_hs,
    output logic               video_vs,
    output logic               video_de,
    output logic [23:0]        video_rgb,
    output logic               data_req,
    output logic [COORD_W-1:0] pixel_xpos,
    output logic [COORD_W-1:0] pixel_ypos,
    output logic               frame_end
);

    // Request window leads the active window by one clock to cover the generator's register.
    localparam coord_t REQ_START = coord_t'(H_SYNC + H_BACK - 1);
    localparam coord_t REQ_END   = coord_t'(H_SYNC + H_BACK + H_DISP - 1);
    localparam coord_t V_START   = coord_t'(V_SYNC + V_BACK);

    coord_t cnt_h, cnt_v;
    logic   h_sync, h_active, h_wrap;
    logic   v_sync, v_active, v_wrap;
    logic   h_req;

    video_axis_counter #(
        .SYNC (H_SYNC), .BACK (H_BACK), .DISP (H_DISP), .TOTAL (H_TOTAL)
    ) u_h_counter (
        .clk    (pixel_clk),
        .rst    (sys_rst),
        .enable (1'b1),
        .count  (cnt_h),
        .sync   (h_sync),
        .active (h_active),
        .wrap   (h_wrap)
    );

    video_axis_counter #(
        .SYNC (V_SYNC), .BACK (V_BACK), .DISP (V_DISP), .TOTAL (V_TOTAL)
    ) u_v_counter (
        .clk    (pixel_clk),
        .rst    (sys_rst),
        .enable (h_wrap),
        .count  (cnt_v),
        .sync   (v_sync),
        .active (v_active),
        .wrap   (v_wrap)
    );

    assign h_req = (cnt_h >= REQ_START) && (cnt_h < REQ_END);

    assign video_hs   = h_sync ? SYNC_POL : ~SYNC_POL;
    assign video_vs   = v_sync ? SYNC_POL : ~SYNC_POL;
    assign video_de   = v_active && h_active;
    assign data_req   = v_active && h_req;
    assign pixel_xpos = data_req ? cnt_h - REQ_START : '0;
    assign pixel_ypos = data_req ? cnt_v - V_START : '0;
    assign video_rgb  = video_de ? pixel_data : BLACK;
    assign frame_end  = v_wrap;

endmodule

// File: tb/tb_video_timing_driver.sv
// Bench for video_timing_driver on a reduced raster: spec-derived reference counters, an RGB
// scoreboard fed on each data_req, per-frame tallies, mid-frame reset, and an inverted-polarity twin.
module tb_video_timing_driver;
    import video_timing_pkg::*;

    localparam int HS = 4, HB = 6, HD = 16, HT = 30;
    localparam int VS = 2, VB = 3, VD = 8,  VT = 15;
    localparam int FRAME_CLKS = HT * VT;
    localparam int RESTART_LAT = (VS + VB) * HT + HS + HB - 1;

    logic        pixel_clk = 1'b0;
    logic        sys_rst   = 1'b1;
    logic [23:0] pixel_data = '0;

    logic        hs_p, vs_p, de_p, req_p, fe_p;
    logic [23:0] rgb_p;
    logic [10:0] x_p, y_p;
    logic        hs_n, vs_n, de_n, req_n, fe_n;
    logic [23:0] rgb_n;
    logic [10:0] x_n, y_n;

    video_timing_driver #(
        .H_SYNC(11'(HS)), .H_BACK(11'(HB)), .H_DISP(11'(HD)), .H_TOTAL(11'(HT)),
        .V_SYNC(11'(VS)), .V_BACK(11'(VB)), .V_DISP(11'(VD)), .V_TOTAL(11'(VT)),
        .SYNC_POL(1'b1)
    ) dut (
        .pixel_clk(pixel_clk), .sys_rst(sys_rst), .pixel_data(pixel_data),
        .video_hs(hs_p), .video_vs(vs_p), .video_de(de_p), .video_rgb(rgb_p),
        .data_req(req_p), .pixel_xpos(x_p), .pixel_ypos(y_p), .frame_end(fe_p)
    );

    video_timing_driver #(
        .H_SYNC(11'(HS)), .H_BACK(11'(HB)), .H_DISP(11'(HD)), .H_TOTAL(11'(HT)),
        .V_SYNC(11'(VS)), .V_BACK(11'(VB)), .V_DISP(11'(VD)), .V_TOTAL(11'(VT)),
        .SYNC_POL(1'b0)
    ) dut_neg (
        .pixel_clk(pixel_clk), .sys_rst(sys_rst), .pixel_data(pixel_data),
        .video_hs(hs_n), .video_vs(vs_n), .video_de(de_n), .video_rgb(rgb_n),
        .data_req(req_n), .pixel_xpos(x_n), .pixel_ypos(y_n), .frame_end(fe_n)
    );

    always #5 pixel_clk = ~pixel_clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference raster position, advanced from the timing description alone.
    int rh = 0, rv = 0;
    always @(posedge pixel_clk) begin
        if (sys_rst) begin
            rh <= 0;
            rv <= 0;
        end else if (rh == HT - 1) begin
            rh <= 0;
            rv <= (rv == VT - 1) ? 0 : rv + 1;
        end else begin
            rh <= rh + 1;
        end
    end

    logic        mon_en = 1'b0;
    logic [23:0] sb[$];
    int          de_cnt = 0, req_cnt = 0, clk_cnt = 0, frames = 0;

    always @(negedge pixel_clk) begin
        if (mon_en) begin
            automatic logic vact = (rv >= VS + VB) && (rv < VS + VB + VD);
            automatic logic de_e = vact && (rh >= HS + HB) && (rh < HS + HB + HD);
            automatic logic rq_e = vact && (rh >= HS + HB - 1) && (rh < HS + HB + HD - 1);
            automatic int   x_e  = rq_e ? rh - (HS + HB - 1) : 0;
            automatic int   y_e  = rq_e ? rv - (VS + VB) : 0;
            automatic logic [7:0] x8 = 8'(x_e);
            automatic logic [7:0] y8 = 8'(y_e);

            check("hs", hs_p, rh < HS);
            check("vs", vs_p, rv < VS);
            check("de", de_p, de_e);
            check("data_req", req_p, rq_e);
            check("xpos", x_p, x_e);
            check("ypos", y_p, y_e);
            check("frame_end", fe_p, (rh == HT - 1) && (rv == VT - 1));

            check("neg_hs", hs_n, !(rh < HS));
            check("neg_vs", vs_n, !(rv < VS));
            check("neg_de", de_n, de_e);
            check("neg_req", req_n, rq_e);
            check("neg_rgb", rgb_n, rgb_p);

            if (sys_rst) begin
                sb.delete();
                de_cnt = 0; req_cnt = 0; clk_cnt = 0;
            end else begin
                if (de_p) begin
                    if (sb.size() == 0) check("sb_underflow", 32'd1, 32'd0);
                    else                check("rgb", rgb_p, sb.pop_front());
                end else begin
                    check("rgb_idle", rgb_p, 32'd0);
                end
                if (req_p) sb.push_back({x8, y8, 8'hA5});

                clk_cnt++;
                if (de_p)  de_cnt++;
                if (req_p) req_cnt++;
                if (fe_p) begin
                    check("frame_period", clk_cnt, FRAME_CLKS);
                    check("frame_de_cycles", de_cnt, HD * VD);
                    check("frame_req_cycles", req_cnt, HD * VD);
                    frames++;
                    de_cnt = 0; req_cnt = 0; clk_cnt = 0;
                end
            end
            // Generator model: registers the coordinate encoding requested this cycle.
            pixel_data = {x_p[7:0], y_p[7:0], 8'hA5};
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_hs"},   hs_p, 1'b1);
        check({tag, "_vs"},   vs_p, 1'b1);
        check({tag, "_de"},   de_p, 1'b0);
        check({tag, "_req"},  req_p, 1'b0);
        check({tag, "_rgb"},  rgb_p, 32'd0);
        check({tag, "_xpos"}, x_p, 32'd0);
        check({tag, "_ypos"}, y_p, 32'd0);
        check({tag, "_fe"},   fe_p, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        sys_rst = 1'b1;
        @(posedge pixel_clk);
        mon_en = 1'b1;
        repeat (2) @(posedge pixel_clk);
        #1 check_reset_values("reset");
        #1 sys_rst = 1'b0;

        // Three full frames, then the first-line request edge of a fresh frame after reset.
        repeat (3 * FRAME_CLKS) @(posedge pixel_clk);
        check("frames_seen", frames, 3);

        n = 0;
        while (!(rv == 6 && rh == 12) && n < 2 * FRAME_CLKS) begin
            @(posedge pixel_clk);
            n++;
        end
        check("reach_mid_frame", (rv == 6 && rh == 12), 1'b1);
        #2 sys_rst = 1'b1;
        repeat (3) @(posedge pixel_clk);
        #1 check_reset_values("mid_reset");
        #1 sys_rst = 1'b0;

        n = 0;
        while (!req_p && n < 2 * FRAME_CLKS) begin
            @(posedge pixel_clk);
            #1 n++;
        end
        check("restart_latency", n, RESTART_LAT);
        check("restart_xpos", x_p, 32'd0);
        check("restart_ypos", y_p, 32'd0);

        frames = 0;
        repeat (2 * FRAME_CLKS) @(posedge pixel_clk);
        check("frames_after_reset", frames, 2);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
